// File: rtl/hazard_ctrl.sv
// Pipeline interlock: load-use stall/bubble, memory-wait freeze with a watchdog,
// and saturating counters for bubble and freeze cycles.
module hazard_ctrl #(
    parameter int REG_WORDS = 32,
    parameter int ADDR_LEFT = $clog2(REG_WORDS) - 1,
    parameter int TIMEOUT   = 64,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_LEFT:0] r1_addr_s2,
    input  logic [ADDR_LEFT:0] r2_addr_s2,
    input  logic               r1_used_s2,
    input  logic               r2_used_s2,
    input  logic [ADDR_LEFT:0] waddr_s3,
    input  logic               rw_s3,
    input  logic               mem_rd_s3,
    input  logic               mem_req_s4,
    input  logic               mem_ready,
    input  logic               cnt_clr,
    output logic               stall,
    output logic               bubble_s3,
    output logic               freeze,
    output logic               mem_timeout,
    output logic [CNT_W-1:0]   load_stall_cnt,
    output logic [CNT_W-1:0]   mem_wait_cnt
);

    localparam int WC_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        TIMED_OUT = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [WC_W-1:0]   wait_cnt;
    logic [WC_W-1:0]   next_wait_cnt;
    logic              load_hz;
    logic              mem_wait;
    logic              r1_hit;
    logic              r2_hit;

    assign r1_hit   = r1_used_s2 && (r1_addr_s2 == waddr_s3);
    assign r2_hit   = r2_used_s2 && (r2_addr_s2 == waddr_s3);
    assign load_hz  = rw_s3 && mem_rd_s3 && (waddr_s3 != '0) && (r1_hit || r2_hit);
    assign mem_wait = mem_req_s4 && !mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait_cnt;
        end
    end

    // wait_cnt holds the number of freeze cycles already completed, so the current
    // waiting cycle is freeze number wait_cnt+1; the last allowed one moves to TIMED_OUT.
    always_comb begin
        next_state    = state;
        next_wait_cnt = wait_cnt;
        case (state)
            RUN: begin
                if (mem_wait) begin
                    next_state    = MEM_WAIT;
                    next_wait_cnt = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready || !mem_req_s4) begin
                    next_state    = RUN;
                    next_wait_cnt = '0;
                end else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
                    next_state = TIMED_OUT;
                end else begin
                    next_wait_cnt = wait_cnt + 1'b1;
                end
            end
            TIMED_OUT: begin
                next_state = TIMED_OUT;
            end
            default: begin
                next_state    = RUN;
                next_wait_cnt = '0;
            end
        endcase
    end

    always_comb begin
        stall       = 1'b0;
        bubble_s3   = 1'b0;
        freeze      = 1'b0;
        mem_timeout = 1'b0;
        if (!rst) begin
            if (state == TIMED_OUT) begin
                stall       = 1'b1;
                freeze      = 1'b1;
                mem_timeout = 1'b1;
            end else begin
                freeze    = mem_wait;
                stall     = mem_wait || load_hz;
                bubble_s3 = load_hz && !mem_wait;
            end
        end
    end

    // A clear wins over any increment arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_stall_cnt <= '0;
            mem_wait_cnt   <= '0;
        end else if (cnt_clr) begin
            load_stall_cnt <= '0;
            mem_wait_cnt   <= '0;
        end else begin
            if (bubble_s3 && (load_stall_cnt != '1)) begin
                load_stall_cnt <= load_stall_cnt + 1'b1;
            end
            if (freeze && (state != TIMED_OUT) && (mem_wait_cnt != '1)) begin
                mem_wait_cnt <= mem_wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (TIMEOUT=8, CNT_W=4) with a per-cycle
// behavioural model plus literal checkpoints.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] r1_addr_s2;
    logic [4:0] r2_addr_s2;
    logic       r1_used_s2;
    logic       r2_used_s2;
    logic [4:0] waddr_s3;
    logic       rw_s3;
    logic       mem_rd_s3;
    logic       mem_req_s4;
    logic       mem_ready;
    logic       cnt_clr;
    logic       stall;
    logic       bubble_s3;
    logic       freeze;
    logic       mem_timeout;
    logic [3:0] load_stall_cnt;
    logic [3:0] mem_wait_cnt;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(
        .REG_WORDS(32),
        .TIMEOUT  (8),
        .CNT_W    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .r1_addr_s2    (r1_addr_s2),
        .r2_addr_s2    (r2_addr_s2),
        .r1_used_s2    (r1_used_s2),
        .r2_used_s2    (r2_used_s2),
        .waddr_s3      (waddr_s3),
        .rw_s3         (rw_s3),
        .mem_rd_s3     (mem_rd_s3),
        .mem_req_s4    (mem_req_s4),
        .mem_ready     (mem_ready),
        .cnt_clr       (cnt_clr),
        .stall         (stall),
        .bubble_s3     (bubble_s3),
        .freeze        (freeze),
        .mem_timeout   (mem_timeout),
        .load_stall_cnt(load_stall_cnt),
        .mem_wait_cnt  (mem_wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count of consecutive freeze cycles, a sticky timeout flag and
    // integer counters clipped at 15.
    int m_run  = 0;
    bit m_to   = 1'b0;
    int m_lcnt = 0;
    int m_mcnt = 0;
    bit e_stall, e_bub, e_frz, e_to, e_lh, e_mw;

    always @(negedge clk) begin
        e_lh = rw_s3 && mem_rd_s3 && (waddr_s3 != 0) &&
               ((r1_used_s2 && r1_addr_s2 == waddr_s3) || (r2_used_s2 && r2_addr_s2 == waddr_s3));
        e_mw = mem_req_s4 && !mem_ready;
        if (rst) begin
            {e_stall, e_bub, e_frz, e_to} = 4'b0000;
            m_run = 0; m_to = 1'b0; m_lcnt = 0; m_mcnt = 0;
        end else if (m_to) begin
            {e_stall, e_bub, e_frz, e_to} = 4'b1011;
        end else begin
            e_frz   = e_mw;
            e_stall = e_mw || e_lh;
            e_bub   = e_lh && !e_mw;
            e_to    = 1'b0;
        end
        cmp("model_stall", int'(stall), int'(e_stall));
        cmp("model_bubble", int'(bubble_s3), int'(e_bub));
        cmp("model_freeze", int'(freeze), int'(e_frz));
        cmp("model_timeout", int'(mem_timeout), int'(e_to));
        cmp("model_lcnt", int'(load_stall_cnt), m_lcnt);
        cmp("model_mcnt", int'(mem_wait_cnt), m_mcnt);
        if (!rst) begin
            if (cnt_clr) begin
                m_lcnt = 0;
                m_mcnt = 0;
            end else begin
                if (e_bub && m_lcnt < 15) m_lcnt++;
                if (e_frz && !m_to && m_mcnt < 15) m_mcnt++;
            end
            if (!m_to) begin
                if (e_mw) begin
                    m_run++;
                    if (m_run == 8) m_to = 1'b1;
                end else begin
                    m_run = 0;
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] a1, input logic [4:0] a2,
                                 input logic u1, input logic u2,
                                 input logic [4:0] wa, input logic w, input logic ld,
                                 input logic req, input logic rdy, input logic clr);
        r1_addr_s2 = a1;
        r2_addr_s2 = a2;
        r1_used_s2 = u1;
        r2_used_s2 = u2;
        waddr_s3   = wa;
        rw_s3      = w;
        mem_rd_s3  = ld;
        mem_req_s4 = req;
        mem_ready  = rdy;
        cnt_clr    = clr;
    endtask

    task automatic checkOutput(input string name, input logic es, input logic eb,
                               input logic ef, input logic et);
        cmp({name, "_stall"}, int'(stall), int'(es));
        cmp({name, "_bubble"}, int'(bubble_s3), int'(eb));
        cmp({name, "_freeze"}, int'(freeze), int'(ef));
        cmp({name, "_timeout"}, int'(mem_timeout), int'(et));
    endtask

    task automatic checkCounts(input string name, input int el, input int em);
        cmp({name, "_lcnt"}, int'(load_stall_cnt), el);
        cmp({name, "_mcnt"}, int'(mem_wait_cnt), em);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(5, 0, 1, 0, 5, 1, 1, 1, 0, 0);
        #3;
        checkOutput("reset", 0, 0, 0, 0);
        checkCounts("reset", 0, 0);
        cycle();
        cycle();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        $display("[TB] load-use hazard cases");
        applyStimulus(5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
        #2; checkOutput("loaduse", 1, 1, 0, 0); checkCounts("loaduse", 0, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2; checkOutput("idle", 0, 0, 0, 0); checkCounts("loaduse_after", 1, 0);
        cycle();
        applyStimulus(0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        #2; checkOutput("waddr0", 0, 0, 0, 0);
        cycle();
        applyStimulus(5, 0, 0, 0, 5, 1, 1, 0, 0, 0);
        #2; checkOutput("unused_src", 0, 0, 0, 0);
        cycle();
        applyStimulus(0, 5, 0, 1, 5, 1, 1, 0, 0, 0);
        #2; checkOutput("src2_hit", 1, 1, 0, 0);
        cycle();
        applyStimulus(5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
        #2; checkOutput("not_load", 0, 0, 0, 0); checkCounts("hazard_mix", 2, 0);
        cycle();

        $display("[TB] memory wait with concurrent load-use");
        applyStimulus(5, 0, 1, 0, 5, 1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #2; checkOutput("memwait", 1, 0, 1, 0);
            cycle();
        end
        applyStimulus(5, 0, 1, 0, 5, 1, 1, 1, 1, 0);
        #2; checkOutput("memready", 1, 1, 0, 0); checkCounts("memwait", 2, 3);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2; checkOutput("run_again", 0, 0, 0, 0); checkCounts("memready", 3, 3);
        cycle();

        $display("[TB] watchdog timeout");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            #2; checkOutput("wait_pre_to", 1, 0, 1, 0);
            cycle();
        end
        #2; checkOutput("timeout", 1, 0, 1, 1); checkCounts("timeout", 3, 11);
        applyStimulus(5, 0, 1, 0, 5, 1, 1, 1, 1, 0);
        #1; checkOutput("timeout_ready", 1, 0, 1, 1);
        cycle();
        #2; checkOutput("timeout_sticky", 1, 0, 1, 1); checkCounts("timeout_sticky", 3, 11);

        $display("[TB] asynchronous reset");
        rst = 1'b1;
        #1; checkOutput("rst_async", 0, 0, 0, 0); checkCounts("rst_async", 0, 0);
        cycle();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2; checkOutput("rst_release", 0, 0, 0, 0);
        cycle();
        applyStimulus(5, 0, 1, 0, 5, 1, 1, 1, 0, 0);
        #2; checkOutput("wait_c1", 1, 0, 1, 0);
        cycle();
        #2; rst = 1'b1;
        #1; checkOutput("rst_midwait", 0, 0, 0, 0); checkCounts("rst_midwait", 0, 0);
        cycle();
        rst = 1'b0;
        #2; checkOutput("post_rst_wait", 1, 0, 1, 0); checkCounts("post_rst", 0, 0);
        cycle();
        #2; checkOutput("post_rst_wait2", 1, 0, 1, 0); checkCounts("post_rst2", 0, 1);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        $display("[TB] counter saturation and clear");
        applyStimulus(7, 0, 1, 0, 7, 1, 1, 0, 0, 0);
        repeat (20) cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2; checkCounts("saturate", 15, 2);
        cycle();
        applyStimulus(7, 0, 1, 0, 7, 1, 1, 0, 0, 1);
        #2; checkOutput("clr_bubble", 1, 1, 0, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2; checkCounts("cleared", 0, 0);
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
